// File: rtl/halut_result_collector.sv
// Collects per-unit halut decoder results into round-robin arbitrated slots feeding a FWFT FIFO.
// Optional rectification on FIFO write is enabled by defining HALUT_COLLECTOR_RELU_EN.
module halut_result_collector #(
  parameter int unsigned DecoderUnits = 16,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned FifoDepth    = 8,
  parameter int unsigned UnitIdxWidth = $clog2(DecoderUnits),
  parameter int unsigned CountWidth   = $clog2(FifoDepth) + 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear_i,
  input  logic [DecoderUnits*DataWidth-1:0] result_i,
  input  logic [DecoderUnits-1:0]           valid_i,
  output logic [DataWidth-1:0]              data_o,
  output logic [UnitIdxWidth-1:0]           idx_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [CountWidth-1:0]             count_o,
  output logic                              overflow_o
);

  localparam int unsigned PtrWidth = $clog2(FifoDepth);

  typedef struct packed {
    logic [UnitIdxWidth-1:0] idx;
    logic [DataWidth-1:0]    data;
  } entry_t;

  function automatic logic [DataWidth-1:0] rectify(input logic [DataWidth-1:0] d);
`ifdef HALUT_COLLECTOR_RELU_EN
    return d[DataWidth-1] ? '0 : d;
`else
    return d;
`endif
  endfunction

  logic [DecoderUnits-1:0] valid_q;
  logic [DecoderUnits-1:0] capture;
  logic [DecoderUnits-1:0] slot_full_q, slot_full_d;
  logic [DataWidth-1:0]    slot_data_q [DecoderUnits];
  logic [DataWidth-1:0]    slot_data_d [DecoderUnits];
  logic [UnitIdxWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic                    overflow_q, overflow_d;

  entry_t                  mem_q [FifoDepth];
  entry_t                  head_q, head_d;
  entry_t                  push_entry;
  logic [PtrWidth-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CountWidth-1:0]   count_q, count_d;
  logic [CountWidth-1:0]   fill_after_pop;

  logic                    grant_valid;
  logic [UnitIdxWidth-1:0] grant_idx;
  logic                    fifo_full;
  logic                    push;
  logic                    pop;

  assign capture   = valid_i & ~valid_q;
  assign fifo_full = (count_q == CountWidth'(FifoDepth));
  assign pop       = (count_q != '0) & ready_i;
  assign push      = grant_valid & (~fifo_full | pop);

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    int unsigned u;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < DecoderUnits; i++) begin
      u = (32'(rr_ptr_q) + i) % DecoderUnits;
      if (!grant_valid && slot_full_q[u]) begin
        grant_valid = 1'b1;
        grant_idx   = UnitIdxWidth'(u);
      end
    end
  end

  always_comb begin
    push_entry.idx  = grant_idx;
    push_entry.data = rectify(slot_data_q[grant_idx]);
  end

  // A slot granted this cycle is emptied first, so a same-cycle capture refills it without loss.
  always_comb begin
    slot_full_d = slot_full_q;
    slot_data_d = slot_data_q;
    overflow_d  = overflow_q;
    rr_ptr_d    = rr_ptr_q;
    if (push) begin
      slot_full_d[grant_idx] = 1'b0;
      rr_ptr_d = (grant_idx == UnitIdxWidth'(DecoderUnits - 1)) ? '0 : grant_idx + 1'b1;
    end
    for (int unsigned u = 0; u < DecoderUnits; u++) begin
      if (capture[u]) begin
        if (!slot_full_d[u]) begin
          slot_full_d[u] = 1'b1;
          slot_data_d[u] = result_i[u*DataWidth +: DataWidth];
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  // The head register always holds the entry at rd_ptr_d, or zero when the FIFO will be empty.
  always_comb begin
    wr_ptr_d       = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d       = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fill_after_pop = count_q - CountWidth'(pop);
    count_d        = fill_after_pop + CountWidth'(push);
    if (fill_after_pop == '0) begin
      head_d = push ? push_entry : '0;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q     <= '0;
      slot_full_q <= '0;
      rr_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
    end else if (clear_i) begin
      valid_q     <= '0;
      slot_full_q <= '0;
      rr_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
    end else begin
      valid_q     <= valid_i;
      slot_full_q <= slot_full_d;
      rr_ptr_q    <= rr_ptr_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
    end
  end

  // NOTE: data storage is not reset; the full flags and FIFO count gate every read of it.
  always_ff @(posedge clk_i) begin
    slot_data_q <= slot_data_d;
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign data_o     = head_q.data;
  assign idx_o      = head_q.idx;
  assign valid_o    = (count_q != '0);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: doc/halut_result_collector.md
Name: halut_result_collector

Overview:
- Sits directly downstream of the bank of halut decoder units.
- Captures each unit's FP32 `result`/`valid` pulse into a per-unit holding slot.
- Arbitrates the slots round-robin into a FIFO and drains the FIFO through a valid/ready stream tagged with the unit index.
- Decouples the free-running decoders from a back-pressured consumer (writeback or DMA).

Parameters:
- DecoderUnits, 16, number of decoder units feeding the collector.
- DataWidth, 32, result width (FP32).
- FifoDepth, 8, output FIFO entries; power of two, >= 2.
- UnitIdxWidth, $clog2(DecoderUnits), width of unit index tag.
- CountWidth, $clog2(FifoDepth)+1, width of occupancy count.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- clear_i  input  1  synchronous flush of slots, FIFO, overflow and arbiter pointer.
- result_i  input  DecoderUnits*DataWidth  packed per-unit FP32 results; unit u at bits [u*DataWidth +: DataWidth].
- valid_i  input  DecoderUnits  per-unit result valid; may stay high for several cycles.
- data_o  output  DataWidth  head-of-FIFO result.
- idx_o  output  UnitIdxWidth  unit index of `data_o`.
- valid_o  output  1  FIFO non-empty.
- ready_i  input  1  consumer accepts the head when `valid_o & ready_i`.
- count_o  output  CountWidth  FIFO occupancy.
- overflow_o  output  1  sticky: a result was lost.

Behaviour:
- Reset (async) and `clear_i` (sync) set:
  - slots empty;
  - `valid_q` (registered copy of `valid_i`) = 0;
  - FIFO empty, `count_o` = 0, `valid_o` = 0;
  - `data_o` = 0, `idx_o` = 0;
  - `overflow_o` = 0;
  - round-robin pointer = 0.
- `clear_i` has priority over all activity in the same cycle. Reset mid-operation discards everything.
- Capture:
  - A capture event for unit u is a rising edge, `valid_i[u] & ~valid_q[u]`.
  - On capture, slot u loads `result_i[u]` and becomes full.
  - A sustained high `valid_i` captures once.
- Arbitration:
  - Each cycle, if the FIFO is not full, or is full and being popped this cycle, grant the first full slot searching from the pointer upward with wrap.
  - The granted slot's `{u, data}` is written to the FIFO and the slot becomes empty.
  - The pointer moves to grant+1 (mod DecoderUnits). No grant leaves the pointer unchanged.
  - At most one slot moves per cycle.
- Simultaneous capture and grant on the same slot: the old data goes to the FIFO, the new data is loaded, and the slot stays full. This is not an overflow.
- Capture into a full slot that is not granted this cycle: the old data is kept, the new data is dropped, and `overflow_o` sets (sticky until reset or clear).
- FIFO:
  - First-word-fall-through; `data_o`/`idx_o` are driven from a registered head entry.
  - Push and pop in the same cycle is allowed, including when full.
  - Pop when empty is ignored.
  - Pointers wrap modulo FifoDepth.
  - `count_o` = pushes − pops, range 0..FifoDepth.
- Latency with an empty FIFO and idle arbiter:
  - `valid_i` rises at edge t;
  - slot full after t;
  - FIFO write at edge t+1;
  - `valid_o` = 1 after edge t+1, i.e. 2 cycles.
- `data_o`/`idx_o` hold stable while `valid_o & ~ready_i`.
- No arithmetic on data other than the optional feature.

Optional Feature:
- Macro: HALUT_COLLECTOR_RELU_EN.
- When defined, results are rectified on FIFO write:
  - if sign bit 31 = 1, the stored value is 32'h0000_0000 (covers −0.0 and negatives);
  - NaN with the sign bit set also maps to 0.
- When undefined, results pass bit-exact.

Test Plan:
- Single result: reset; `valid_i[3]` rises with 32'h3F80_0000 held 4 cycles; `ready_i`=1 -> exactly one beat, `data_o`=32'h3F80_0000, `idx_o`=3, `valid_o` first high 2 cycles after the edge; `count_o` returns to 0.
- Round-robin order: all 16 `valid_i` rise together, data = 32'h4000_0000+u, `ready_i`=1 -> `idx_o` sequence 0..15, one per cycle, no overflow.
- Backpressure: `ready_i`=0, 16 units fire -> `count_o` saturates at 8, 8 results remain in slots, `overflow_o`=0; raise `ready_i` -> all 16 delivered in order 0..15.
- Overflow and same-cycle capture:
  - unit 5 fires twice while the FIFO is full and the slot is ungranted -> `overflow_o`=1, first value delivered, second lost;
  - repeat with the second capture coinciding with the grant of slot 5 -> both delivered, `overflow_o`=0.
- Clear and reset mid-stream: 5 entries queued, `clear_i` pulse -> next cycle `valid_o`=0, `count_o`=0, `overflow_o`=0; assert `rst_ni`=0 asynchronously mid-transfer -> all outputs 0 immediately.
- RELU_EN: with the macro, inputs 32'hBF80_0000 and 32'h8000_0000 -> `data_o`=32'h0; 32'h4040_0000 -> unchanged. Without the macro, all inputs pass bit-exact.
